// File: rtl/magnetron_timer_pkg.sv
// Shared microwave timer definitions: BCD digit width and limits, the
// countdown state encoding, a packed three-digit time record and helpers
// for keypad shift-in and one-second decrement.
package magnetron_timer_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] MAX_SEC_TENS = 4'd5;
  localparam logic [BCD_W-1:0] MAX_DIGIT    = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } timer_state_t;

  typedef struct packed {
    logic [BCD_W-1:0] min_ones;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] sec_ones;
  } bcd_time_t;

  function automatic logic time_nonzero(input bcd_time_t t);
    return |t;
  endfunction

  // Keys enter from the right; a seconds-ones digit above 5 cannot become
  // a valid tens-of-seconds digit, so it is clamped on the way through.
  function automatic bcd_time_t bcd_shift(input bcd_time_t t,
                                          input logic [BCD_W-1:0] key);
    bcd_time_t r;
    r.min_ones = t.sec_tens;
    r.sec_tens = (t.sec_ones > MAX_SEC_TENS) ? MAX_SEC_TENS : t.sec_ones;
    r.sec_ones = key;
    return r;
  endfunction

  // One-second decrement with BCD borrow; saturates at 0:00.
  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sec_ones != '0) begin
      r.sec_ones = t.sec_ones - 1'b1;
    end else if (t.sec_tens != '0) begin
      r.sec_ones = MAX_DIGIT;
      r.sec_tens = t.sec_tens - 1'b1;
    end else if (t.min_ones != '0) begin
      r.sec_ones = MAX_DIGIT;
      r.sec_tens = MAX_SEC_TENS;
      r.min_ones = t.min_ones - 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/magnetron_timer_tick_gen.sv
// One-second prescaler for the magnetron timer.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-high reset
//   en    - count enable; when low the counter is held at zero
//   tick  - one-cycle pulse while en is high and the count is TICK_DIV-1
module tick_gen #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!en) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/magnetron_timer.sv
// Microwave cook timer: keypad entry of an M:SS time and a one-second
// countdown while the magnetron runs.
// Ports:
//   clk          - system clock
//   reset        - asynchronous active-high reset
//   clearn       - active-low synchronous clear of the entered time
//   magnetron_on - magnetron running level; enables the countdown
//   key_data     - BCD digit from the keypad encoder
//   key_valid    - one-cycle strobe qualifying key_data
//   min_ones     - minutes digit
//   sec_tens     - tens-of-seconds digit
//   sec_ones     - seconds digit
//   timer_done   - high whenever the displayed time is 0:00
module magnetron_timer
  import magnetron_timer_pkg::*;
#(
  parameter int TICK_DIV = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clearn,
  input  logic             magnetron_on,
  input  logic [BCD_W-1:0] key_data,
  input  logic             key_valid,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic             timer_done
);

  timer_state_t state_q;
  bcd_time_t    cur_time;
  bcd_time_t    shifted_time;
  bcd_time_t    dec_time;
  logic         key_ok;
  logic         tick_en;
  logic         tick;

  assign cur_time     = {min_ones, sec_tens, sec_ones};
  assign shifted_time = bcd_shift(cur_time, key_data);
  assign dec_time     = bcd_dec(cur_time);
  assign timer_done   = !time_nonzero(cur_time);

  assign key_ok = key_valid && (key_data <= MAX_DIGIT) && !magnetron_on && clearn;

  // The prescaler only runs while actually counting down; any pause, clear
  // or expiry returns it to zero so a resume always waits a full second.
  assign tick_en = (state_q == ST_RUN) && magnetron_on && clearn && !timer_done;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .en   (tick_en),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min_ones <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
      state_q  <= ST_IDLE;
    end else if (!clearn) begin
      min_ones <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
      state_q  <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (key_ok) begin
            {min_ones, sec_tens, sec_ones} <= shifted_time;
            state_q <= time_nonzero(shifted_time) ? ST_ARMED : ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (magnetron_on) begin
            state_q <= timer_done ? ST_IDLE : ST_RUN;
          end else if (key_ok) begin
            {min_ones, sec_tens, sec_ones} <= shifted_time;
            state_q <= time_nonzero(shifted_time) ? ST_ARMED : ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!magnetron_on) begin
            // Pause; a key arriving in the same cycle is still honoured.
            if (key_ok) begin
              {min_ones, sec_tens, sec_ones} <= shifted_time;
              state_q <= time_nonzero(shifted_time) ? ST_ARMED : ST_IDLE;
            end else begin
              state_q <= timer_done ? ST_IDLE : ST_ARMED;
            end
          end else if (tick) begin
            {min_ones, sec_tens, sec_ones} <= dec_time;
            state_q <= time_nonzero(dec_time) ? ST_RUN : ST_IDLE;
          end else if (timer_done) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_magnetron_timer.sv
module tb_magnetron_timer;
  import magnetron_timer_pkg::*;

  logic       clk;
  logic       reset;
  logic       clearn;
  logic       magnetron_on;
  logic [3:0] key_data;
  logic       key_valid;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       timer_done;

  int checks;
  int errors;

  magnetron_timer #(.TICK_DIV(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .clearn      (clearn),
    .magnetron_on(magnetron_on),
    .key_data    (key_data),
    .key_valid   (key_valid),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .timer_done  (timer_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] key;
    logic       valid;
    logic       on;
    logic       clr_n;
    logic [3:0] exp_m;
    logic [3:0] exp_t;
    logic [3:0] exp_o;
    logic       exp_done;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_time(input string name, input logic [3:0] m, input logic [3:0] t,
                          input logic [3:0] o);
    chk(name, {20'd0, min_ones, sec_tens, sec_ones}, {20'd0, m, t, o});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_data  = k;
    key_valid = 1'b1;
    step(1);
    key_valid = 1'b0;
  endtask

  task automatic do_clear();
    clearn = 1'b0;
    step(1);
    clearn = 1'b1;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    clearn       = 1'b1;
    magnetron_on = 1'b0;
    key_data     = 4'd0;
    key_valid    = 1'b0;

    //          key    vld   on    clrn  m     t     o     done
    vecs[0]  = '{4'd1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd1, 1'b0};
    vecs[1]  = '{4'd3, 1'b1, 1'b0, 1'b1, 4'd0, 4'd1, 4'd3, 1'b0};
    vecs[2]  = '{4'd0, 1'b1, 1'b0, 1'b1, 4'd1, 4'd3, 4'd0, 1'b0};
    vecs[3]  = '{4'hA, 1'b1, 1'b0, 1'b1, 4'd1, 4'd3, 4'd0, 1'b0};
    vecs[4]  = '{4'd5, 1'b0, 1'b0, 1'b1, 4'd1, 4'd3, 4'd0, 1'b0};
    vecs[5]  = '{4'd7, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1};
    vecs[6]  = '{4'd9, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd9, 1'b0};
    vecs[7]  = '{4'd9, 1'b1, 1'b0, 1'b1, 4'd0, 4'd5, 4'd9, 1'b0};
    vecs[8]  = '{4'd4, 1'b1, 1'b1, 1'b1, 4'd0, 4'd5, 4'd9, 1'b0};
    vecs[9]  = '{4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1};
    vecs[10] = '{4'd3, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 1'b1};

    #12;
    chk_time("reset_digits", 4'd0, 4'd0, 4'd0);
    chk("reset_done", {31'd0, timer_done}, 32'd1);
    chk("reset_state", 32'(dut.state_q), 32'(ST_IDLE));
    reset = 1'b0;
    step(1);

    // Keypad entry, clamp, invalid keys, clear and magnetron interlock.
    for (int i = 0; i < 11; i++) begin
      key_data     = vecs[i].key;
      key_valid    = vecs[i].valid;
      magnetron_on = vecs[i].on;
      clearn       = vecs[i].clr_n;
      step(1);
      key_valid = 1'b0;
      clearn    = 1'b1;
      chk_time($sformatf("vec%0d_time", i), vecs[i].exp_m, vecs[i].exp_t, vecs[i].exp_o);
      chk($sformatf("vec%0d_done", i), {31'd0, timer_done}, {31'd0, vecs[i].exp_done});
      if (i == 2) chk("vec2_state_armed", 32'(dut.state_q), 32'(ST_ARMED));
      if (i == 8) chk("vec8_state_run", 32'(dut.state_q), 32'(ST_RUN));
      if (i == 9) chk("vec9_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    end
    magnetron_on = 1'b0;
    step(1);

    // 0:02 countdown to expiry; first tick arrives 4 cycles after entering RUN.
    press(4'd2);
    chk_time("cd_load", 4'd0, 4'd0, 4'd2);
    magnetron_on = 1'b1;
    step(1);
    chk("cd_state_run", 32'(dut.state_q), 32'(ST_RUN));
    step(3);
    chk_time("cd_before_tick", 4'd0, 4'd0, 4'd2);
    step(1);
    chk_time("cd_first_tick", 4'd0, 4'd0, 4'd1);
    step(4);
    chk_time("cd_zero", 4'd0, 4'd0, 4'd0);
    chk("cd_done", {31'd0, timer_done}, 32'd1);
    chk("cd_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    step(6);
    chk_time("cd_hold_zero", 4'd0, 4'd0, 4'd0);
    magnetron_on = 1'b0;
    step(1);

    // 1:00 -> 0:59 borrow chain.
    press(4'd1);
    press(4'd0);
    press(4'd0);
    chk_time("borrow_load", 4'd1, 4'd0, 4'd0);
    magnetron_on = 1'b1;
    step(5);
    chk_time("borrow_tick", 4'd0, 4'd5, 4'd9);
    magnetron_on = 1'b0;
    step(1);
    do_clear();

    // Pause and resume.
    press(4'd5);
    magnetron_on = 1'b1;
    step(1);
    step(6);
    chk_time("pause_running", 4'd0, 4'd0, 4'd4);
    chk("pause_presc_mid", 32'(dut.u_tick_gen.count), 32'd2);
    magnetron_on = 1'b0;
    step(1);
    chk("pause_state_armed", 32'(dut.state_q), 32'(ST_ARMED));
    chk("pause_presc_zero", 32'(dut.u_tick_gen.count), 32'd0);
    step(3);
    chk_time("pause_hold", 4'd0, 4'd0, 4'd4);
    magnetron_on = 1'b1;
    step(1);
    step(3);
    chk_time("resume_before_tick", 4'd0, 4'd0, 4'd4);
    step(1);
    chk_time("resume_tick", 4'd0, 4'd0, 4'd3);
    magnetron_on = 1'b0;
    step(1);
    do_clear();

    // Clear coincident with a pending tick and a key strobe.
    press(4'd3);
    magnetron_on = 1'b1;
    step(4);
    chk("clr_tick_pending", {31'd0, dut.tick}, 32'd1);
    clearn    = 1'b0;
    key_data  = 4'd7;
    key_valid = 1'b1;
    step(1);
    clearn    = 1'b1;
    key_valid = 1'b0;
    chk_time("clr_time", 4'd0, 4'd0, 4'd0);
    chk("clr_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    chk("clr_presc", 32'(dut.u_tick_gen.count), 32'd0);
    magnetron_on = 1'b0;
    step(1);

    // Asynchronous reset in the middle of RUN.
    press(4'd7);
    magnetron_on = 1'b1;
    step(3);
    reset = 1'b1;
    #1;
    chk_time("rst_run_time", 4'd0, 4'd0, 4'd0);
    chk("rst_run_done", {31'd0, timer_done}, 32'd1);
    chk("rst_run_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("rst_run_presc", 32'(dut.u_tick_gen.count), 32'd0);
    step(2);
    reset = 1'b0;
    step(5);
    chk_time("rst_after_time", 4'd0, 4'd0, 4'd0);
    magnetron_on = 1'b0;
    step(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
